// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: multicycle writeback sequencer driving the integer register
// file write port. Takes a command from the control FSM, sources the result from
// the ALU or from a data-memory load, and issues one rf write pulse plus done.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             command strobe (sampled only in IDLE)
//   src_sel           0 = ALU result, 1 = load
//   funct3            load type (LB/LH/LW/LBU/LHU)
//   rd_in             destination register
//   alu_result        ALU value, or load byte address
//   mem_req_valid/ready, mem_addr      load request channel
//   mem_rsp_valid, mem_rsp_data        load response channel
//   rf_we, rf_rd, rf_wdata             register-file write port
//   busy, done, err                    status to the control FSM
module rf_writeback_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  src_sel,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] rd_in,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic                  rf_we,
   output logic [ADDR_WIDTH-1:0] rf_rd,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

   state_t                state, state_d;
   logic [2:0]            cap_f3, cap_f3_d;
   logic [ADDR_WIDTH-1:0] cap_rd, cap_rd_d;
   logic [1:0]            cap_lane, cap_lane_d;

   logic                  mem_req_valid_d, rf_we_d, busy_d, done_d, err_d;
   logic [DATA_WIDTH-1:0] mem_addr_d, rf_wdata_d;
   logic [ADDR_WIDTH-1:0] rf_rd_d;

   // Legality of a load given its type and the low address bits.
   function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'd0, 3'd4: load_legal = 1'b1;
         3'd1, 3'd5: load_legal = ~lane[0];
         3'd2:       load_legal = (lane == 2'b00);
         default:    load_legal = 1'b0;
      endcase
   endfunction

   // Select the addressed byte/half lane and sign- or zero-extend it.
   function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                         input logic [1:0] lane,
                                                         input logic [DATA_WIDTH-1:0] word);
      logic [DATA_WIDTH-1:0] sh_b;
      logic [DATA_WIDTH-1:0] sh_h;
      sh_b = word >> {lane, 3'b000};
      sh_h = word >> {lane[1], 4'b0000};
      case (f3)
         3'd0:    load_extend = {{(DATA_WIDTH-BYTE_W){sh_b[BYTE_W-1]}}, sh_b[BYTE_W-1:0]};
         3'd1:    load_extend = {{(DATA_WIDTH-HALF_W){sh_h[HALF_W-1]}}, sh_h[HALF_W-1:0]};
         3'd4:    load_extend = {{(DATA_WIDTH-BYTE_W){1'b0}}, sh_b[BYTE_W-1:0]};
         3'd5:    load_extend = {{(DATA_WIDTH-HALF_W){1'b0}}, sh_h[HALF_W-1:0]};
         default: load_extend = word;
      endcase
   endfunction

   // State, captured command and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cap_f3        <= '0;
         cap_rd        <= '0;
         cap_lane      <= '0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         rf_we         <= 1'b0;
         rf_rd         <= '0;
         rf_wdata      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_d;
         cap_f3        <= cap_f3_d;
         cap_rd        <= cap_rd_d;
         cap_lane      <= cap_lane_d;
         mem_req_valid <= mem_req_valid_d;
         mem_addr      <= mem_addr_d;
         rf_we         <= rf_we_d;
         rf_rd         <= rf_rd_d;
         rf_wdata      <= rf_wdata_d;
         busy          <= busy_d;
         done          <= done_d;
         err           <= err_d;
      end
   end

   // Next state and next output values; outputs are computed one cycle ahead
   // so they are registered yet valid in the state they belong to.
   always_comb begin
      state_d         = state;
      cap_f3_d        = cap_f3;
      cap_rd_d        = cap_rd;
      cap_lane_d      = cap_lane;
      mem_req_valid_d = 1'b0;
      mem_addr_d      = mem_addr;
      rf_we_d         = 1'b0;
      rf_rd_d         = rf_rd;
      rf_wdata_d      = rf_wdata;
      done_d          = 1'b0;
      err_d           = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               cap_f3_d   = funct3;
               cap_rd_d   = rd_in;
               cap_lane_d = alu_result[1:0];
               if (!src_sel) begin
                  state_d    = WRITE;
                  rf_we_d    = (rd_in != '0);
                  rf_rd_d    = rd_in;
                  rf_wdata_d = alu_result;
                  done_d     = 1'b1;
               end else if (!load_legal(funct3, alu_result[1:0])) begin
                  // Illegal load: complete without touching memory or the rf.
                  state_d = WRITE;
                  rf_rd_d = rd_in;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d         = REQ;
                  mem_req_valid_d = 1'b1;
                  mem_addr_d      = {alu_result[DATA_WIDTH-1:2], 2'b00};
               end
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = WAIT;
            else               mem_req_valid_d = 1'b1;
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               state_d    = WRITE;
               rf_we_d    = (cap_rd != '0);
               rf_rd_d    = cap_rd;
               rf_wdata_d = load_extend(cap_f3, cap_lane, mem_rsp_data);
               done_d     = 1'b1;
            end
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule
